// File: rtl/inc_dec_counter.sv
// inc_dec_counter: up/down modulo counter built on a prefix-AND incrementer-decrementer.
// Define INC_DEC_COUNTER_SAT_EN for saturating instead of wrapping at the terminal values.
module inc_dec_counter #(
    parameter int               WIDTH  = 8,
    parameter int               SPEED  = 2,
    parameter logic [WIDTH-1:0] MAXVAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             en_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] q_o,
    output logic             tc_o,
    output logic             co_o,
    output logic             ovf_o
);
    localparam int N = WIDTH - 1;
    localparam int L = $clog2(N);
`ifdef INC_DEC_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    function automatic logic [N-1:0] pre_serial(input logic [N-1:0] p);
        logic [N-1:0] a;
        a = p;
        for (int i = 1; i < N; i++) a[i] = a[i] & a[i-1];
        return a;
    endfunction

    function automatic logic [N-1:0] pre_bk(input logic [N-1:0] p);
        logic [N-1:0] a;
        a = p;
        for (int l = 0; l < L; l++)
            for (int i = 0; i < N; i++)
                if ((i + 1) % (1 << (l + 1)) == 0) a[i] = a[i] & a[i-(1<<l)];
        // down-sweep fills in the odd-span nodes from completed prefixes below them
        for (int l = L - 1; l >= 0; l--)
            for (int i = 0; i < N; i++)
                if ((i + 1) % (1 << (l + 1)) == (1 << l) && i > (1 << l)) a[i] = a[i] & a[i-(1<<l)];
        return a;
    endfunction

    function automatic logic [N-1:0] pre_sk(input logic [N-1:0] p);
        logic [N-1:0] a;
        a = p;
        for (int l = 0; l < L; l++)
            for (int i = 0; i < N; i++)
                if (((i >> l) & 1) == 1) a[i] = a[i] & a[((i >> l) << l) - 1];
        return a;
    endfunction

    logic [WIDTH-1:0] q_q, q_d, nxt, ld_val;
    logic             co_q, co_d, ovf_q, ovf_d, term;
    logic [N-1:0]     p, pre;

    // toggle bit i when all lower bits are 1 (up) or all 0 (down); carry-in is 1
    assign p      = q_q[N-1:0] ^ {N{dec_i}};
    assign pre    = SPEED == 0 ? pre_serial(p) : SPEED == 1 ? pre_bk(p) : pre_sk(p);
    assign nxt    = q_q ^ {pre, 1'b1};
    assign term   = dec_i ? q_q == '0 : q_q == MAXVAL;
    assign ld_val = d_i > MAXVAL ? MAXVAL : d_i;
    assign tc_o   = en_i & ~clr_i & ~ld_i & term;

    always_comb begin
        q_d   = q_q;
        co_d  = 1'b0;
        ovf_d = ovf_q;
        if (clr_i) begin
            q_d   = '0;
            ovf_d = 1'b0;
        end else if (ld_i) begin
            q_d = ld_val;
        end else if (en_i) begin
            q_d   = term ? (SAT ? q_q : (dec_i ? MAXVAL : '0)) : nxt;
            co_d  = term;
            ovf_d = ovf_q | term;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q   <= '0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            co_q  <= co_d;
            ovf_q <= ovf_d;
        end
    end

    assign q_o   = q_q;
    assign co_o  = co_q;
    assign ovf_o = ovf_q;
endmodule

// File: tb/tb_inc_dec_counter.sv
// tb_inc_dec_counter: vector table and corner sequences on a width-4/maxval-9 counter,
// plus a random sweep of three width-8 counters (one per prefix structure) against a model.
module tb_inc_dec_counter;
`ifdef INC_DEC_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b1;
    logic       n_clr = 0, n_ld = 0, n_en = 0, n_dec = 0;
    logic [3:0] n_d = '0, n_q;
    logic       n_tc, n_co, n_ovf;
    logic       w_clr = 0, w_ld = 0, w_en = 0, w_dec = 0;
    logic [7:0] w_d = '0;
    logic [7:0] w_q [3];
    logic       w_tc [3], w_co [3], w_ovf [3];
    int         pass_cnt = 0, total_cnt = 0;

    always #5 clk = ~clk;

    inc_dec_counter #(.WIDTH(4), .SPEED(1), .MAXVAL(4'd9)) u_n (
        .clk_i(clk), .rst_i(rst), .clr_i(n_clr), .ld_i(n_ld), .d_i(n_d), .en_i(n_en),
        .dec_i(n_dec), .q_o(n_q), .tc_o(n_tc), .co_o(n_co), .ovf_o(n_ovf));

    for (genvar s = 0; s < 3; s++) begin : g_w
        inc_dec_counter #(.WIDTH(8), .SPEED(s), .MAXVAL(8'd255)) u_w (
            .clk_i(clk), .rst_i(rst), .clr_i(w_clr), .ld_i(w_ld), .d_i(w_d), .en_i(w_en),
            .dec_i(w_dec), .q_o(w_q[s]), .tc_o(w_tc[s]), .co_o(w_co[s]), .ovf_o(w_ovf[s]));
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    typedef struct {
        logic       clr, ld, en, dec;
        logic [3:0] d, q;
        logic       co, ovf, tc;
    } vec_t;

    function automatic vec_t v(input logic c, l, e, dc, input logic [3:0] dd, qq,
                               input logic cc, oo, tt);
        vec_t r;
        r.clr = c; r.ld = l; r.en = e; r.dec = dc; r.d = dd;
        r.q = qq; r.co = cc; r.ovf = oo; r.tc = tt;
        return r;
    endfunction

    vec_t tbl [21];
    int   m, mco, movf, etc, d8;

    initial begin
        // columns: clr ld en dec d | q co ovf tc
        tbl[0]  = v(0, 1, 0, 0, 4'd8,  4'd8, 0, 0, 0);
        tbl[1]  = v(0, 0, 1, 0, 4'd0,  4'd9, 0, 0, 0);
        tbl[2]  = v(0, 0, 1, 0, 4'd0,  SAT ? 4'd9 : 4'd0, 1, 1, 1);
        tbl[3]  = v(0, 0, 0, 0, 4'd0,  SAT ? 4'd9 : 4'd0, 0, 1, 0);
        tbl[4]  = v(0, 1, 1, 0, 4'd15, 4'd9, 0, 1, 0);
        tbl[5]  = v(1, 1, 1, 0, 4'd3,  4'd0, 0, 0, 0);
        tbl[6]  = v(0, 0, 1, 1, 4'd0,  SAT ? 4'd0 : 4'd9, 1, 1, 1);
        tbl[7]  = v(0, 1, 1, 0, 4'd3,  4'd3, 0, 1, 0);
        tbl[8]  = v(0, 0, 1, 1, 4'd0,  4'd2, 0, 1, 0);
        tbl[9]  = v(0, 0, 1, 0, 4'd0,  4'd3, 0, 1, 0);
        tbl[10] = v(0, 0, 0, 1, 4'd0,  4'd3, 0, 1, 0);
        tbl[11] = v(1, 0, 0, 0, 4'd0,  4'd0, 0, 0, 0);
        tbl[12] = v(0, 0, 1, 0, 4'd0,  4'd1, 0, 0, 0);
        tbl[13] = v(0, 1, 0, 0, 4'd9,  4'd9, 0, 0, 0);
        tbl[14] = v(0, 0, 1, 1, 4'd0,  4'd8, 0, 0, 0);
        tbl[15] = v(0, 0, 1, 0, 4'd0,  4'd9, 0, 0, 0);
        tbl[16] = v(0, 0, 1, 0, 4'd0,  SAT ? 4'd9 : 4'd0, 1, 1, 1);
        tbl[17] = v(0, 0, 1, 0, 4'd0,  SAT ? 4'd9 : 4'd1, SAT, 1, SAT);
        tbl[18] = v(0, 1, 0, 0, 4'd0,  4'd0, 0, 1, 0);
        tbl[19] = v(0, 0, 1, 1, 4'd0,  SAT ? 4'd0 : 4'd9, 1, 1, 1);
        tbl[20] = v(0, 0, 1, 1, 4'd0,  SAT ? 4'd0 : 4'd8, SAT, 1, SAT);

        #1;
        chk("reset q", int'(n_q), 0);
        chk("reset co", int'(n_co), 0);
        chk("reset ovf", int'(n_ovf), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            if (i > 0) @(negedge clk);
            n_clr = tbl[i].clr; n_ld = tbl[i].ld; n_en = tbl[i].en; n_dec = tbl[i].dec; n_d = tbl[i].d;
            #1 chk($sformatf("vec%0d tc", i), int'(n_tc), int'(tbl[i].tc));
            @(posedge clk); #1;
            chk($sformatf("vec%0d q", i), int'(n_q), int'(tbl[i].q));
            chk($sformatf("vec%0d co", i), int'(n_co), int'(tbl[i].co));
            chk($sformatf("vec%0d ovf", i), int'(n_ovf), int'(tbl[i].ovf));
        end

        // async reset mid-count with the sticky flag set
        @(negedge clk);
        n_clr = 0; n_ld = 1; n_en = 0; n_d = 4'd5;
        @(posedge clk); #1 chk("preload q", int'(n_q), 5);
        chk("preload ovf sticky", int'(n_ovf), 1);
        @(negedge clk);
        n_ld = 0; n_en = 1; n_dec = 0;
        #2 rst = 1'b1;
        #1;
        chk("async rst q", int'(n_q), 0);
        chk("async rst co", int'(n_co), 0);
        chk("async rst ovf", int'(n_ovf), 0);
        @(posedge clk); #1 chk("rst held q", int'(n_q), 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1 chk("first after rst q", int'(n_q), 1);
        @(negedge clk) n_en = 0;

        // random sweep on the wide counters
        m = 0; movf = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            w_clr = (i == 0) || ($urandom_range(0, 99) < 3);
            w_ld  = $urandom_range(0, 99) < 8;
            w_en  = $urandom_range(0, 9) != 0;
            w_dec = 1'($urandom_range(0, 1));
            d8 = $urandom_range(0, 3);
            w_d = d8 == 0 ? 8'd0 : d8 == 1 ? 8'd255 : d8 == 2 ? 8'd1 : 8'($urandom_range(0, 255));
            etc = (w_en && !w_clr && !w_ld && (w_dec ? m == 0 : m == 255)) ? 1 : 0;
            if (w_clr) begin
                m = 0; mco = 0; movf = 0;
            end else if (w_ld) begin
                m = int'(w_d); mco = 0;
            end else if (w_en) begin
                mco = etc;
                movf = movf | etc;
                if (!(SAT && etc)) m = (m + (w_dec ? 255 : 1)) % 256;
            end else mco = 0;
            #1;
            for (int s = 0; s < 3; s++) chk($sformatf("rnd%0d s%0d tc", i, s), int'(w_tc[s]), etc);
            @(posedge clk); #1;
            for (int s = 0; s < 3; s++) begin
                chk($sformatf("rnd%0d s%0d q", i, s), int'(w_q[s]), m);
                chk($sformatf("rnd%0d s%0d co", i, s), int'(w_co[s]), mco);
                chk($sformatf("rnd%0d s%0d ovf", i, s), int'(w_ovf[s]), movf);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
